encrypt_sequencer: RTL and testbench
====================================

# encrypt_sequencer

Hardware sequencer for the Program #1 message-encryption job on the accumulator's data memory. It takes over the single data-memory port and reads the configuration bytes and the raw ASCII message. It computes the 7-bit LFSR keystream and writes the 64 parity-tagged cipher bytes to addresses 64..127. Completion is signalled on the same `req`/`ack` handshake used by `top_level`. It serves as a hardware reference and accelerator that sits beside the core, muxed onto the data-memory port.

## Interface
Parameters:
- `MSG_MAX`, 52: maximum message characters read from memory.
- `OUT_LEN`, 64: cipher bytes produced.
- `OUT_BASE`, 64: first output address.

Ports:
- `clk` in 1: the single clock; all state updates on rising edge.
- `init` in 1: reset, synchronous and active-high.
- `req` in 1: high holds the block idle; low while idle launches a run.
- `ack` out 1: run complete; stays high until `req` rises.
- `busy` out 1: high from launch until the last write.
- `mem_addr` out 8: data-memory address.
- `mem_wr_en` out 1: write strobe.
- `mem_wdata` out 8: write data.
- `mem_rdata` in 8: read data, combinational from `mem_addr` in the same cycle.

## Operation
- States: IDLE, LD_PRE, LD_TAP, LD_SEED, RD, WR, DONE.
- IDLE: if `req`=0, go to LD_PRE and set `i`=0.
- LD_PRE: `mem_addr`=61; latch `pre` (8 bits).
- LD_TAP: `mem_addr`=62; latch `taps`=`mem_rdata[6:0]`.
- LD_SEED: `mem_addr`=63; latch `lfsr`=`mem_rdata[6:0]`.
- Seed 0 is used as-is and yields an all-zero keystream; there is no substitution.
- RD: compute `k`=`i`−`pre`.
  - If `i`<`pre` or `k`≥`MSG_MAX`: `plain`=0x00 and `mem_addr` is driven with `k[7:0]`, but the data is ignored.
  - Otherwise `mem_addr`=`k` and `plain`=(`mem_rdata`−0x20)[6:0].
- WR: `mem_addr`=`OUT_BASE`+`i`, `mem_wr_en`=1.
  - `c[6:0]`=`plain`^`lfsr`, `c[7]`=^`c[6:0]`.
  - Then `lfsr`←{`lfsr[5:0]`, ^(`lfsr`&`taps`)} and `i`←`i`+1.
  - If `i`=`OUT_LEN`−1, go to DONE; otherwise go to RD.
- DONE: `ack`=1, `busy`=0. When `req`=1, return to IDLE with `ack` cleared.
- Arithmetic: `i` is a 7-bit counter. The `pre` comparison uses full 8-bit width, so `pre`≥64 makes every byte padding. The subtraction of 0x20 is modulo 256, truncated to 7 bits.
- `req` changes during LD_*/RD/WR are ignored.

## Timing
- Reset (`init`=1 at a rising edge): next state is IDLE; `ack`=0, `busy`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0; `i`, `lfsr`, `taps` and `pre` are cleared.
- Reset mid-run aborts immediately. No further writes occur; bytes already written stay in memory.
- Launch: the first cycle with `req`=0 in IDLE is cycle 0, and the state is LD_PRE at cycle 1.
- Fixed latency: 3 load cycles plus 2×64 RD/WR cycles = 131 cycles, then DONE.
- `ack` rises on cycle 132 after launch.
- Exactly 64 write strobes occur per run, one per WR cycle, at strictly increasing addresses 64..127.
- `mem_wr_en` is never asserted outside WR.

## Structure
- Package `enc_pkg` holds:
  - the state enum `enc_state_t`;
  - constants `ADDR_PRE`=61, `ADDR_TAP`=62, `ADDR_SEED`=63, `ASCII_BIAS`=8'h20;
  - the nine legal tap patterns `LFSR_PTRN[9]` (60, 48, 78, 72, 6A, 69, 5C, 7E, 7B hex).
- Sub-module `lfsr7`: 7-bit register with `load`, `step`, `seed`, `taps` and `state` ports. It is shared with the later decrypt sequencer.

## Test plan
- `pre`=10, `taps`=0x60, seed=0x01, message "Mr. Watson…":
  - required: mem[64]=0x81, mem[65]=0x82, mem[74]=0xA5 ('M' with `lfsr`=0x08);
  - all 64 bytes match the bench model.
- Seed 0, `pre`=12, message all spaces: every output byte is 0x00, and `ack` rises 132 cycles after launch.
- `req` held at 1 for 50 cycles after reset: no write strobes, `busy`=0, `ack`=0.
- `init` pulsed at cycle 40 of a run: the block is in IDLE on the next cycle, writes stop at address ≤ 64+18, and a relaunch completes correctly.
- Full 52-character message with `pre`=15: only addresses 0..48 are read as message, and bytes 64+63 and earlier padding positions encrypt 0x00.
- All nine `LFSR_PTRN` values with a random nonzero seed: output matches the model, and `ack` clears within one cycle after `req` rises in DONE.

Source files
------------

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and constants for the encryption sequencer
package enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_PRE,
    LD_TAP,
    LD_SEED,
    RD,
    WR,
    DONE
  } enc_state_t;

  localparam logic [7:0] ADDR_PRE   = 8'd61;
  localparam logic [7:0] ADDR_TAP   = 8'd62;
  localparam logic [7:0] ADDR_SEED  = 8'd63;
  localparam logic [7:0] ASCII_BIAS = 8'h20;

  // The nine maximal-length feedback patterns the message format allows.
  localparam logic [6:0] LFSR_PTRN [9] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  // Cipher byte: 7 data bits with their XOR parity in bit 7.
  function automatic logic [7:0] parity_tag(input logic [6:0] d);
    return {^d, d};
  endfunction

endpackage

// File: rtl/encrypt_sequencer_if.sv
// rtl/encrypt_sequencer_if.sv - req/ack handshake plus data-memory port bundle
interface encrypt_sequencer_if;

  logic       req;
  logic       ack;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  // Sequencer side: owns the memory port and the completion flags.
  modport master (
    input  req,
    input  mem_rdata,
    output ack,
    output busy,
    output mem_addr,
    output mem_wr_en,
    output mem_wdata
  );

  // Host/memory side.
  modport slave (
    output req,
    output mem_rdata,
    input  ack,
    input  busy,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wdata
  );

endinterface

// File: rtl/encrypt_sequencer_lfsr7.sv
// rtl/encrypt_sequencer_lfsr7.sv - 7-bit Fibonacci LFSR, shared with the decrypt sequencer
module lfsr7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [6:0] seed,
  input  logic [6:0] taps,
  output logic [6:0] state
);

  // Load wins over step; new bit enters at the LSB as the parity of tapped bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (step) begin
      state <= {state[5:0], ^(state & taps)};
    end
  end

endmodule

// File: rtl/encrypt_sequencer.sv
// rtl/encrypt_sequencer.sv - Program #1 message encryption sequencer on the data-memory port
module encrypt_sequencer
  import enc_pkg::*;
#(
  parameter int MSG_MAX  = 52,
  parameter int OUT_LEN  = 64,
  parameter int OUT_BASE = 64
) (
  input logic                 clk,
  input logic                 init,
  encrypt_sequencer_if.master bus
);

  enc_state_t state;
  logic [6:0] i;
  logic [7:0] pre;
  logic [6:0] taps;
  logic [6:0] lfsr;

  logic       ack_r;
  logic       busy_r;
  logic [7:0] addr_r;
  logic       wr_en_r;
  logic [7:0] wdata_r;

  logic [6:0] i_inc;
  logic [7:0] k_cur;
  logic [7:0] k_next;
  logic       pad;
  logic [6:0] plain;
  logic [6:0] cipher;

  assign i_inc  = i + 7'd1;
  assign k_cur  = {1'b0, i} - pre;
  assign k_next = {1'b0, i_inc} - pre;

  // Leading padding (i < pre, full 8-bit compare) and anything past the message encrypt zero.
  assign pad    = ({1'b0, i} < pre) || (k_cur >= 8'(MSG_MAX));
  assign plain  = pad ? 7'd0 : 7'(bus.mem_rdata - ASCII_BIAS);
  assign cipher = plain ^ lfsr;

  lfsr7 u_lfsr (
    .clk   (clk),
    .rst   (init),
    .load  (state == LD_SEED),
    .step  (state == WR),
    .seed  (bus.mem_rdata[6:0]),
    .taps  (taps),
    .state (lfsr)
  );

  // Sequencer FSM; outputs are registered, so each transition sets up the next state's bus values.
  always_ff @(posedge clk) begin
    if (init) begin
      state   <= IDLE;
      i       <= '0;
      pre     <= '0;
      taps    <= '0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      addr_r  <= '0;
      wr_en_r <= 1'b0;
      wdata_r <= '0;
    end else begin
      wr_en_r <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.req) begin
            state  <= LD_PRE;
            i      <= '0;
            busy_r <= 1'b1;
            addr_r <= ADDR_PRE;
          end
        end
        LD_PRE: begin
          pre    <= bus.mem_rdata;
          addr_r <= ADDR_TAP;
          state  <= LD_TAP;
        end
        LD_TAP: begin
          taps   <= bus.mem_rdata[6:0];
          addr_r <= ADDR_SEED;
          state  <= LD_SEED;
        end
        LD_SEED: begin
          addr_r <= k_cur;
          state  <= RD;
        end
        RD: begin
          addr_r  <= 8'(OUT_BASE) + {1'b0, i};
          wr_en_r <= 1'b1;
          wdata_r <= parity_tag(cipher);
          state   <= WR;
        end
        WR: begin
          i <= i_inc;
          if (i == 7'(OUT_LEN - 1)) begin
            state  <= DONE;
            ack_r  <= 1'b1;
            busy_r <= 1'b0;
            addr_r <= '0;
          end else begin
            state  <= RD;
            addr_r <= k_next;
          end
        end
        DONE: begin
          if (bus.req) begin
            state <= IDLE;
            ack_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_r;
  assign bus.busy      = busy_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wr_en = wr_en_r;
  assign bus.mem_wdata = wdata_r;

endmodule

// File: tb/tb_encrypt_sequencer.sv
// tb/tb_encrypt_sequencer.sv - self-checking bench for encrypt_sequencer
module tb_encrypt_sequencer;
  import enc_pkg::*;

  localparam int MSG_MAX  = 52;
  localparam int OUT_LEN  = 64;
  localparam int OUT_BASE = 64;

  logic clk = 1'b0;
  logic init;

  always #5 clk = ~clk;

  encrypt_sequencer_if bus();

  encrypt_sequencer #(
    .MSG_MAX  (MSG_MAX),
    .OUT_LEN  (OUT_LEN),
    .OUT_BASE (OUT_BASE)
  ) dut (
    .clk  (clk),
    .init (init),
    .bus  (bus)
  );

  logic [7:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];

  int n_asserts = 0;
  int n_fail    = 0;
  int wr_count;
  int order_err;
  int last_wr_addr;
  int busy_seen;
  int ack_seen;
  logic [7:0] exp_out [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample outputs at the falling edge and apply any memory write.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (bus.mem_wr_en === 1'b1) begin
      if (wr_count > 0 && int'(bus.mem_addr) <= last_wr_addr) order_err++;
      if (bus.mem_addr < 8'(OUT_BASE) || int'(bus.mem_addr) >= OUT_BASE + OUT_LEN) order_err++;
      last_wr_addr = int'(bus.mem_addr);
      mem[bus.mem_addr] = bus.mem_wdata;
      wr_count++;
    end
    if (bus.busy === 1'b1) busy_seen++;
    if (bus.ack === 1'b1) ack_seen++;
  endtask

  task automatic clear_log();
    wr_count     = 0;
    order_err    = 0;
    last_wr_addr = -1;
    busy_seen    = 0;
    ack_seen     = 0;
  endtask

  task automatic fill_msg(input bit any_byte);
    for (int k = 0; k < 61; k++)
      mem[k] = any_byte ? 8'($urandom_range(0, 255)) : 8'($urandom_range(32, 126));
  endtask

  // Config bytes; the unused top bits of taps/seed are randomised.
  task automatic setup(input logic [7:0] p, input logic [6:0] t, input logic [6:0] s);
    mem[61] = p;
    mem[62] = {1'($urandom_range(0, 1)), t};
    mem[63] = {1'($urandom_range(0, 1)), s};
    for (int k = 64; k < 128; k++) mem[k] = 8'hEE;
  endtask

  // Reference: plain integer arithmetic over the message stored in bench memory.
  task automatic build_model();
    int p, t, l, k, pl, c, fb;
    p = int'(mem[61]);
    t = int'(mem[62]) & 127;
    l = int'(mem[63]) & 127;
    for (int j = 0; j < OUT_LEN; j++) begin
      k = j - p;
      if (k < 0 || k >= MSG_MAX) pl = 0;
      else pl = (int'(mem[k]) - 32) & 127;
      c = pl ^ l;
      exp_out[j] = 8'(c | (($countones(c) & 1) << 7));
      fb = $countones(l & t) & 1;
      l = ((l << 1) & 127) | fb;
    end
  endtask

  task automatic run_and_check(input string tag, input bit toggle_req);
    int lat;
    build_model();
    clear_log();
    bus.req = 1'b0;
    lat = 0;
    while (bus.ack !== 1'b1 && lat < 400) begin
      cyc();
      lat++;
      if (toggle_req && lat == 60) bus.req = 1'b1;
      if (toggle_req && lat == 61) bus.req = 1'b0;
    end
    check($sformatf("%s:latency", tag), lat, 132);
    check($sformatf("%s:writes", tag), wr_count, 64);
    check($sformatf("%s:order", tag), order_err, 0);
    check($sformatf("%s:busy_cycles", tag), busy_seen, 131);
    for (int j = 0; j < OUT_LEN; j++)
      check($sformatf("%s:byte%0d", tag, j), mem[OUT_BASE + j], exp_out[j]);
    bus.req = 1'b1;
    cyc();
    check($sformatf("%s:ack_clear", tag), bus.ack, 1'b0);
    check($sformatf("%s:busy_clear", tag), bus.busy, 1'b0);
  endtask

  initial begin
    string s;
    init    = 1'b1;
    bus.req = 1'b1;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    clear_log();
    repeat (3) cyc();

    check("rst:ack", bus.ack, 1'b0);
    check("rst:busy", bus.busy, 1'b0);
    check("rst:wr_en", bus.mem_wr_en, 1'b0);
    check("rst:addr", bus.mem_addr, 8'h00);
    check("rst:wdata", bus.mem_wdata, 8'h00);

    // Idle hold: req high keeps the block quiet.
    init = 1'b0;
    clear_log();
    repeat (50) cyc();
    check("idle:writes", wr_count, 0);
    check("idle:busy", busy_seen, 0);
    check("idle:ack", ack_seen, 0);

    // Known message with a short req glitch mid-run that must be ignored.
    s = "Mr. Watson, come here. I want to see you.";
    for (int k = 0; k < 61; k++) mem[k] = (k < s.len()) ? s[k] : 8'h20;
    setup(8'd10, 7'h60, 7'h01);
    run_and_check("watson", 1'b1);
    check("watson:mem64", mem[64], 8'h81);
    check("watson:mem65", mem[65], 8'h82);

    // Zero seed over spaces: keystream and plaintext both zero.
    for (int k = 0; k < 61; k++) mem[k] = 8'h20;
    setup(8'd12, 7'h60, 7'h00);
    run_and_check("seed0", 1'b0);
    for (int j = 0; j < OUT_LEN; j++)
      check($sformatf("seed0:zero%0d", j), mem[OUT_BASE + j], 8'h00);

    // Reset during RD of byte 18: bytes 0..17 written, nothing after.
    fill_msg(1'b0);
    setup(8'd5, 7'h48, 7'h35);
    clear_log();
    bus.req = 1'b0;
    repeat (40) cyc();
    init    = 1'b1;
    bus.req = 1'b1;
    cyc();
    check("abort:wr_en", bus.mem_wr_en, 1'b0);
    check("abort:busy", bus.busy, 1'b0);
    check("abort:ack", bus.ack, 1'b0);
    check("abort:addr", bus.mem_addr, 8'h00);
    init = 1'b0;
    repeat (5) cyc();
    check("abort:writes", wr_count, 18);
    check("abort:last_addr", last_wr_addr, 81);
    fill_msg(1'b0);
    setup(8'd3, 7'h78, 7'h5A);
    run_and_check("relaunch", 1'b0);

    // Full 52-byte message of arbitrary bytes (exercises the modulo bias subtraction).
    fill_msg(1'b1);
    setup(8'd15, LFSR_PTRN[$urandom_range(0, 8)], 7'($urandom_range(1, 127)));
    run_and_check("full52", 1'b0);

    // Preamble beyond the output length: everything is padding.
    fill_msg(1'b0);
    setup(8'd200, 7'h6A, 7'($urandom_range(1, 127)));
    run_and_check("pre200", 1'b0);

    // Every legal tap pattern with a random nonzero seed.
    for (int p = 0; p < 9; p++) begin
      fill_msg(1'b0);
      setup(8'($urandom_range(0, 20)), LFSR_PTRN[p], 7'($urandom_range(1, 127)));
      run_and_check($sformatf("ptrn%0d", p), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
